// File: rtl/axi4_wr_slave.sv
// AXI4 write-only slave backed by a 64-bit word memory, one burst at a time.
// Optional address range check enabled by defining AXI_WR_RANGE_CHK_EN.
module axi4_wr_slave #(
    parameter int ID_W       = 8,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_W-1:0]       AWID,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_W-1:0]       BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [DEPTH_LOG2-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [1:0]            state;
    logic [ID_W-1:0]       id_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [7:0]            len_q;
    logic [1:0]            burst_q;
    logic [8:0]            beat_cnt;
    logic                  slv_err;
    logic                  dec_err;

    logic [DATA_W-1:0]     mem [0:(1<<DEPTH_LOG2)-1];

    logic                  w_hs;
    logic                  last_beat;
    logic                  range_err;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] widx;
    logic                  unused_addr;

    assign w_hs      = WVALID && WREADY;
    assign last_beat = (beat_cnt == {1'b0, len_q});
    assign widx      = addr_q[DEPTH_LOG2+2:3];

`ifdef AXI_WR_RANGE_CHK_EN
    assign range_err = ((addr_q >> (DEPTH_LOG2 + 3)) != '0);
`else
    // Upper address bits alias onto the memory when the check is disabled.
    assign range_err = 1'b0;
`endif

    assign mem_we = w_hs && (burst_q != BURST_WRAP) && !range_err;

    // Sub-word offset and (when unchecked) upper bits never select storage.
    assign unused_addr = ^{addr_q[2:0], addr_q[ADDR_W-1:DEPTH_LOG2+3]};

    assign AWREADY = (state == IDLE) && !rst;
    assign WREADY  = (state == DATA);
    assign BVALID  = (state == RESP);
    assign BID     = BVALID ? id_q : '0;
    assign BRESP   = !BVALID ? RESP_OKAY   :
                     dec_err ? RESP_DECERR :
                     slv_err ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            beat_cnt <= '0;
            slv_err  <= 1'b0;
            dec_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (AWVALID) begin
                        id_q     <= AWID;
                        addr_q   <= AWADDR;
                        len_q    <= AWLEN;
                        burst_q  <= AWBURST;
                        beat_cnt <= '0;
                        slv_err  <= 1'b0;
                        dec_err  <= 1'b0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        // FIXED and WRAP keep the start address; everything else steps one word.
                        if (burst_q != BURST_FIXED && burst_q != BURST_WRAP)
                            addr_q <= addr_q + ADDR_W'(8);
                        if ((WLAST != last_beat) || (burst_q == BURST_WRAP))
                            slv_err <= 1'b1;
                        if (range_err)
                            dec_err <= 1'b1;
                        if (last_beat)
                            state <= RESP;
                    end
                end
                RESP: begin
                    if (BREADY)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (WSTRB[b])
                    mem[widx][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_axi4_wr_slave.sv
// Randomized bench for axi4_wr_slave against a word-array reference model.
module tb_axi4_wr_slave;

    localparam int DL    = 10;
    localparam int WORDS = 1 << DL;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    AWID;
    logic [31:0]   AWADDR;
    logic [7:0]    AWLEN;
    logic [1:0]    AWBURST;
    logic          AWVALID;
    logic          AWREADY;
    logic [63:0]   WDATA;
    logic [7:0]    WSTRB;
    logic          WLAST;
    logic          WVALID;
    logic          WREADY;
    logic [7:0]    BID;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [DL-1:0] dbg_addr;
    logic [63:0]   dbg_data;

    axi4_wr_slave #(.ID_W(8), .ADDR_W(32), .DATA_W(64), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] model_mem [WORDS];
    logic [63:0] bd [256];
    logic [7:0]  bs [256];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_word(input int idx);
        dbg_addr = DL'(idx);
        #1;
        check($sformatf("mem[%0d]", idx), dbg_data, model_mem[idx]);
    endtask

    // Reference behaviour of one accepted beat: returns whether the address is out of range.
    task automatic model_beat(input logic [31:0] a, input logic [1:0] burst,
                              input logic [63:0] d, input logic [7:0] s, output logic bad);
        int idx;
`ifdef AXI_WR_RANGE_CHK_EN
        bad = (a >> (DL + 3)) != 0;
`else
        bad = 1'b0;
`endif
        idx = int'((a >> 3) % WORDS);
        if (burst != 2'b10 && !bad)
            for (int b = 0; b < 8; b++)
                if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic fill_beats(input int n, input logic [7:0] strb_all);
        for (int i = 0; i < n; i++) begin
            bd[i] = {$urandom, $urandom};
            bs[i] = (strb_all != 8'h00) ? strb_all : 8'($urandom);
        end
    endtask

    task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int err_beat, input int hold, input int gap_max);
        logic        slv, dec, bad;
        logic [31:0] a;
        logic [1:0]  exp_resp;
        slv = (burst == 2'b10);
        dec = 1'b0;
        @(negedge clk);
        AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
        check("awready_idle", AWREADY, 1);
        @(negedge clk);
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                WVALID = 1'b0;
                @(negedge clk);
            end
            a = (burst == 2'b01) ? addr + 32'(8 * i) : addr;
            WVALID = 1'b1; WDATA = bd[i]; WSTRB = bs[i];
            WLAST = (i == int'(len)) ^ (i == err_beat);
            if (i == err_beat) slv = 1'b1;
            check("wready_data", WREADY, 1);
            model_beat(a, burst, bd[i], bs[i], bad);
            if (bad) dec = 1'b1;
            @(negedge clk);
        end
        WVALID = 1'b0;
        exp_resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
        check("bvalid_after_last", BVALID, 1);
        check("bid", BID, id);
        check("bresp", BRESP, exp_resp);
        BREADY = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            WVALID = 1'b1; WDATA = {$urandom, $urandom}; WSTRB = 8'hFF;
            @(negedge clk);
            check("bvalid_hold", BVALID, 1);
            check("bid_hold", BID, id);
            check("bresp_hold", BRESP, exp_resp);
            check("awready_resp", AWREADY, 0);
            check("wready_resp", WREADY, 0);
        end
        WVALID = 1'b0;
        BREADY = 1'b1;
        @(negedge clk);
        BREADY = 1'b0;
        check("bvalid_cleared", BVALID, 0);
        check("awready_back", AWREADY, 1);
        check_word(int'((addr >> 3) % WORDS));
    endtask

    initial begin
        logic        bad;
        logic [31:0] addr;
        int          len, eb;

        rst = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; dbg_addr = '0;
        #1;
        check("rst_awready", AWREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_bid", BID, 0);
        check("rst_bresp", BRESP, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Initialise every word with full-length (256-beat) INCR bursts.
        for (int k = 0; k < 4; k++) begin
            fill_beats(256, 8'hFF);
            run_burst(8'(k), 32'(k * 2048), 8'd255, 2'b01, -1, 0, 0);
        end
        for (int w = 0; w < WORDS; w++) check_word(w);

        // Four-beat INCR at 0x40 with data 1..4.
        for (int i = 0; i < 4; i++) begin bd[i] = 64'(i + 1); bs[i] = 8'hFF; end
        run_burst(8'h5A, 32'h40, 8'd3, 2'b01, -1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = DL'(8 + i); #1;
            check("incr_word", dbg_data, 64'(i + 1));
        end

        // Partial strobe merge on a FIXED single beat.
        bd[0] = 64'h1111_1111_2222_2222; bs[0] = 8'hFF;
        run_burst(8'h01, 32'h0, 8'd0, 2'b00, -1, 0, 0);
        bd[0] = 64'hAAAA_AAAA_BBBB_BBBB; bs[0] = 8'h0F;
        run_burst(8'h02, 32'h0, 8'd0, 2'b00, -1, 0, 0);
        dbg_addr = '0; #1;
        check("fixed_strb", dbg_data, 64'h1111_1111_BBBB_BBBB);

        // Early WLAST, then WRAP, then long BREADY stall.
        fill_beats(2, 8'hFF);
        run_burst(8'h33, 32'h300, 8'd1, 2'b01, 0, 0, 0);
        fill_beats(4, 8'hFF);
        run_burst(8'h44, 32'h400, 8'd3, 2'b10, -1, 0, 0);
        fill_beats(2, 8'h00);
        run_burst(8'h77, 32'h500, 8'd1, 2'b01, -1, 5, 0);

        // W traffic while idle must be ignored.
        @(negedge clk);
        WVALID = 1'b1; WDATA = 64'hDEAD_BEEF_DEAD_BEEF; WSTRB = 8'hFF; WLAST = 1'b1;
        check("wready_idle", WREADY, 0);
        @(negedge clk);
        WVALID = 1'b0;

        // Reset in the middle of a four-beat burst.
        fill_beats(4, 8'hFF);
        AWID = 8'h99; AWADDR = 32'h600; AWLEN = 8'd3; AWBURST = 2'b01; AWVALID = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            WVALID = 1'b1; WDATA = bd[i]; WSTRB = bs[i]; WLAST = 1'b0;
            model_beat(32'h600 + 32'(8 * i), 2'b01, bd[i], bs[i], bad);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        check("midrst_awready", AWREADY, 0);
        check("midrst_wready", WREADY, 0);
        check("midrst_bvalid", BVALID, 0);
        check("midrst_bid", BID, 0);
        check("midrst_bresp", BRESP, 0);
        WVALID = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_bvalid", BVALID, 0);
        for (int i = 0; i < 4; i++) check_word(int'((32'h600 >> 3) + i));
        fill_beats(2, 8'h00);
        run_burst(8'hA5, 32'h700, 8'd1, 2'b01, -1, 1, 1);

`ifdef AXI_WR_RANGE_CHK_EN
        fill_beats(1, 8'hFF);
        run_burst(8'h3C, 32'h1000_0000, 8'd0, 2'b01, -1, 0, 0);
`endif

        // Randomized bursts.
        for (int t = 0; t < 40; t++) begin
            len  = $urandom_range(15, 0);
            addr = 32'($urandom_range(8191, 0));
            if ($urandom_range(5, 0) == 0) addr[31:13] = 19'($urandom);
            eb   = ($urandom_range(7, 0) == 0) ? int'($urandom_range(len, 0)) : -1;
            fill_beats(len + 1, 8'h00);
            run_burst(8'($urandom), addr, 8'(len), 2'($urandom_range(2, 0)), eb,
                      int'($urandom_range(3, 0)), 2);
        end

        for (int w = 0; w < WORDS; w++) check_word(w);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
